// File: rtl/uart_frame_tx.sv
// Framed byte-stream transmitter: HDR, LEN, queued payload, optional XOR checksum,
// each byte paced on the UART's tx_done. Define FRAME_CKSUM_EN to append the checksum byte.
module uart_frame_tx #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  input  logic       send,
  output logic       busy,
  output logic       frame_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FRAME_CKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;
  typedef enum logic [1:0] {P_HDR, P_LEN, P_PAY, P_CHK} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, len_q, left_q;
  logic [7:0]      tx_q;
  logic            ovf_q, done_q;
  logic            accept, push, pop, fin;
  logic [7:0]      byte_sel;

  assign accept     = send && (state_q == S_IDLE);
  assign full       = (count_q == CW'(DEPTH));
  assign push       = wr_en && !full;
  assign pop        = (state_q == S_ISSUE) && (phase_q == P_PAY);
  assign overflow   = ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign trmt       = (state_q == S_ISSUE);
  assign tx_data    = trmt ? byte_sel : tx_q;

`ifdef FRAME_CKSUM_EN
  logic [7:0] chk_q;

  // Running XOR seeded with LEN, folded with each payload byte as it is popped.
  always_ff @(posedge clk) begin
    if (accept)
      chk_q <= 8'(count_q);
    else if (pop)
      chk_q <= chk_q ^ mem[rd_ptr_q];
  end
`endif

  always_comb begin
    byte_sel = 8'h00;
    case (phase_q)
      P_HDR:   byte_sel = HDR;
      P_LEN:   byte_sel = 8'(len_q);
      P_PAY:   byte_sel = mem[rd_ptr_q];
`ifdef FRAME_CKSUM_EN
      P_CHK:   byte_sel = chk_q;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: if (send) begin
        state_d = S_ISSUE;
        phase_d = P_HDR;
      end
      S_ISSUE: state_d = S_GUARD;
      // tx_done is still stale here; the UART drops it one cycle after trmt.
      S_GUARD: state_d = S_WAIT;
      S_WAIT: if (tx_done) begin
        state_d = S_ISSUE;
        case (phase_q)
          P_HDR: phase_d = P_LEN;
          P_LEN, P_PAY: begin
            if (((phase_q == P_LEN) ? len_q : left_q) != '0)
              phase_d = P_PAY;
            else if (HAS_CHK)
              phase_d = P_CHK;
            else
              fin = 1'b1;
          end
          default: fin = 1'b1;
        endcase
        if (fin)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= P_HDR;
      done_q  <= 1'b0;
      tx_q    <= 8'h00;
      len_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= fin;
      if (trmt)
        tx_q <= byte_sel;
      if (accept) begin
        len_q  <= count_q;
        left_q <= count_q;
      end else if (pop) begin
        left_q <= left_q - 1'b1;
      end
    end
  end

  // Payload FIFO; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (accept)
        ovf_q <= 1'b0;
      else if (wr_en && full)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: frame-level model plus directed literal frames.
module tb_uart_frame_tx;

  localparam int         DEPTH = 8;
  localparam logic [7:0] HDR   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, send, tx_done;
  logic [7:0] wr_data;
  logic       full, overflow, busy, frame_done, trmt;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_frame_tx #(.DEPTH(DEPTH), .HDR(HDR)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .send(send), .busy(busy),
    .frame_done(frame_done), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0] b;
    bit         pay;
    bit         first;
  } ent_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq [$];
  ent_t       exq [$];
  logic [7:0] seen [$];
  bit         m_ovf, m_active, pend_pop, prev_trmt, stale;
  int         fd_cnt = 0;
  int         cyc = 0;
  int         last_trmt_cyc = 0;
  int         acc_cyc = 0;
  int         uart_dly = 20;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seen(input string name, input logic [7:0] want [$]);
    chk8({name, "_len"}, 8'(seen.size()), 8'(want.size()));
    for (int i = 0; i < want.size() && i < seen.size(); i++)
      chk8($sformatf("%s_b%0d", name, i), seen[i], want[i]);
  endtask

  // UART stand-in: drops tx_done after a strobe and raises it uart_dly cycles later.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (stale)
        tx_done = 1'b1;
      else if (trmt === 1'b1) begin
        tx_done = 1'b0;
        repeat (uart_dly) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  // Frame model and per-cycle compare, one step after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        chk8("rst_trmt", trmt, 0);
        chk8("rst_busy", busy, 0);
        chk8("rst_full", full, 0);
        chk8("rst_overflow", overflow, 0);
        chk8("rst_frame_done", frame_done, 0);
        mq.delete();
        exq.delete();
        m_ovf = 0; m_active = 0; pend_pop = 0; prev_trmt = 0;
      end else begin
        bit acc;
        acc = send && !m_active;
        if (acc) begin
          logic [7:0] x;
          int n;
          n = mq.size();
          x = 8'(n);
          m_active = 1; m_ovf = 0; acc_cyc = cyc;
          exq.push_back('{HDR, 1'b0, 1'b1});
          exq.push_back('{8'(n), 1'b0, 1'b0});
          for (int i = 0; i < n; i++) begin
            exq.push_back('{mq[i], 1'b1, 1'b0});
            x = x ^ mq[i];
          end
`ifdef FRAME_CKSUM_EN
          exq.push_back('{x, 1'b0, 1'b0});
`endif
        end
        if (wr_en) begin
          if (mq.size() == DEPTH) begin
            if (!acc) m_ovf = 1;
          end else
            mq.push_back(wr_data);
        end
        if (pend_pop) begin
          void'(mq.pop_front());
          pend_pop = 0;
        end
        chk8("full", full, (mq.size() == DEPTH) ? 8'd1 : 8'd0);
        chk8("overflow", overflow, 8'(m_ovf));
        if (trmt) begin
          chk8("trmt_width", 8'(prev_trmt), 0);
          if (exq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_trmt: got tx_data %h, expected no byte", tx_data);
          end else begin
            ent_t e;
            e = exq.pop_front();
            chk8("tx_data", tx_data, e.b);
            if (e.pay) pend_pop = 1;
            if (e.first)
              chk8("first_trmt_latency", 8'(cyc - acc_cyc), 0);
            else if (stale)
              chk8("stale_gap", 8'(cyc - last_trmt_cyc), 3);
          end
          last_trmt_cyc = cyc;
          seen.push_back(tx_data);
        end
        if (frame_done) begin
          chk8("fd_active", 8'(m_active), 1);
          chk8("fd_bytes_left", 8'(exq.size()), 0);
          m_active = 0;
          fd_cnt++;
        end
        chk8("busy", busy, 8'(m_active));
        prev_trmt = trmt;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_send();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_frame(input int limit);
    int fd0, n;
    fd0 = fd_cnt; n = 0;
    while (fd_cnt == fd0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fd_cnt == fd0) begin
      errors++;
      $display("FAIL frame_done_timeout: got none, expected a pulse within %0d cycles", limit);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] want [$];
    int fd0, n;
    rst_n = 1'b0; wr_en = 1'b0; send = 1'b0; wr_data = 8'h00; stale = 0;
    repeat (3) @(negedge clk);
    chk8("reset_trmt", trmt, 0);
    chk8("reset_busy", busy, 0);
    chk8("reset_full", full, 0);
    chk8("reset_overflow", overflow, 0);
    chk8("reset_frame_done", frame_done, 0);
    chk8("reset_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Three bytes with a slow UART.
    uart_dly = 2170;
    seen.delete();
    push(8'h01); push(8'h02); push(8'h03);
    do_send();
    wait_frame(20000);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
`else
    want = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03};
`endif
    check_seen("three_bytes", want);

    // Empty frame.
    uart_dly = 20;
    seen.delete();
    do_send();
    wait_frame(500);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h00, 8'h00};
`else
    want = '{8'hA5, 8'h00};
`endif
    check_seen("empty", want);

    // Overfill: nine pushes into eight slots.
    seen.delete();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk8("full_after_8", full, 1);
    chk8("ovf_after_8", overflow, 0);
    push(8'h18);
    chk8("full_after_9", full, 1);
    chk8("ovf_after_9", overflow, 1);
    do_send();
    chk8("ovf_cleared_by_send", overflow, 0);
    wait_frame(1000);
    want = '{8'hA5, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
`ifdef FRAME_CKSUM_EN
    want.push_back(8'h08);
`endif
    check_seen("overfill", want);

    // Push and re-send while a frame is in flight.
    seen.delete();
    push(8'hAA); push(8'hBB);
    do_send();
    push(8'h77);
    do_send();
    wait_frame(1000);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
`else
    want = '{8'hA5, 8'h02, 8'hAA, 8'hBB};
`endif
    check_seen("mid_frame_push", want);
    seen.delete();
    do_send();
    wait_frame(1000);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h01, 8'h77, 8'h76};
`else
    want = '{8'hA5, 8'h01, 8'h77};
`endif
    check_seen("leftover_frame", want);

    // Stale tx_done held high: GUARD still spaces strobes three cycles apart.
    stale = 1;
    @(negedge clk);
    seen.delete();
    push(8'h10); push(8'h20);
    do_send();
    wait_frame(200);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
`else
    want = '{8'hA5, 8'h02, 8'h10, 8'h20};
`endif
    check_seen("stale_done", want);
    stale = 0;
    @(negedge clk);

    // Reset during the payload phase.
    seen.delete();
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    do_send();
    push(8'h99);
    chk8("pre_rst_full", full, 1);
    chk8("pre_rst_overflow", overflow, 1);
    n = 0;
    while (seen.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk8("reached_payload", 8'(seen.size() >= 3), 1);
    rst_n = 1'b0;
    fd0 = fd_cnt;
    @(negedge clk);
    chk8("abort_trmt", trmt, 0);
    chk8("abort_busy", busy, 0);
    chk8("abort_full", full, 0);
    chk8("abort_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (uart_dly + 10) @(negedge clk);
    chk8("abort_no_frame_done", 8'(fd_cnt - fd0), 0);
    seen.delete();
    do_send();
    wait_frame(500);
`ifdef FRAME_CKSUM_EN
    want = '{8'hA5, 8'h00, 8'h00};
`else
    want = '{8'hA5, 8'h00};
`endif
    check_seen("after_abort", want);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
